// File: rtl/mic_pdm_capture.sv
// mic_pdm_capture: PDM microphone front end.
// Generates the mic bit clock and synchronises the PDM stream.
// After an optional settling period, it counts ones over fixed windows
// and hands one 16-bit PCM sample per window to a consumer with a valid/rd handshake.
// Optional feature: define MIC_OVERRUN_EN to add the sticky overrun_o flag.
//
// state  | meaning
// IDLE   | capture disabled, counters cleared
// SETTLE | discarding SETTLE whole windows after enable
// ACCUM  | counting ones over a DECIM-bit window
module mic_pdm_capture #(
    parameter int DIV    = 25,
    parameter int DECIM  = 128,
    parameter int SETTLE = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        mic_data_i,
    input  logic        rd_i,
    output logic        mic_clk_o,
    output logic        mic_lr_o,
    output logic [15:0] dout_o,
    output logic        dout_valid_o
`ifdef MIC_OVERRUN_EN
    ,
    output logic        overrun_o
`endif
);

    localparam int LOG2 = $clog2(DECIM);
    localparam int CW   = LOG2 + 1;
    localparam logic [13:0] SETTLE_LOAD = 14'(SETTLE * DECIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM
    } state_t;

    state_t          state_q;
    logic [7:0]      div_q;
    logic            mic_clk_q;
    logic            sync1_q;
    logic            sync2_q;
    logic [13:0]     settle_q;
    logic [CW-1:0]   ones_q;
    logic [CW-1:0]   bits_q;
    logic [15:0]     dout_q;
    logic            valid_q;

    logic            sample_pt;
    logic            window_close;
    logic [CW-1:0]   ones_d;
    logic [CW-1:0]   bits_d;
    logic [LOG2-1:0] sat;
    logic [15:0]     pcm_d;

    // Bit clock divider; held at zero with the clock low while disabled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q     <= 8'd0;
            mic_clk_q <= 1'b0;
        end else if (!en_i) begin
            div_q     <= 8'd0;
            mic_clk_q <= 1'b0;
        end else if (div_q == 8'(DIV - 1)) begin
            div_q     <= 8'd0;
            mic_clk_q <= ~mic_clk_q;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous PDM input.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mic_data_i;
            sync2_q <= sync1_q;
        end
    end

    // A bit is taken on the edge that drives mic_clk low.
    assign sample_pt = en_i && mic_clk_q && (div_q == 8'(DIV - 1));

    // Window arithmetic: next counts, saturated PCM value, close detect.
    always_comb begin
        ones_d       = ones_q + {{LOG2{1'b0}}, sync2_q};
        bits_d       = bits_q + CW'(1);
        sat          = (ones_d > CW'(DECIM - 1)) ? LOG2'(DECIM - 1) : ones_d[LOG2-1:0];
        pcm_d        = {sat, {(16 - LOG2){1'b0}}};
        window_close = (state_q == S_ACCUM) && sample_pt && (bits_d == CW'(DECIM));
    end

    // Capture FSM, window counters and output holding register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            settle_q <= 14'd0;
            ones_q   <= '0;
            bits_q   <= '0;
            dout_q   <= 16'h0000;
            valid_q  <= 1'b0;
`ifdef MIC_OVERRUN_EN
            overrun_o <= 1'b0;
`endif
        end else begin
            // A new sample wins over a simultaneous consume.
            if (window_close) begin
                dout_q  <= pcm_d;
                valid_q <= 1'b1;
            end else if (rd_i && valid_q) begin
                valid_q <= 1'b0;
            end
`ifdef MIC_OVERRUN_EN
            if (window_close && valid_q && !rd_i) begin
                overrun_o <= 1'b1;
            end
`endif
            if (!en_i) begin
                state_q  <= S_IDLE;
                settle_q <= 14'd0;
                ones_q   <= '0;
                bits_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (SETTLE == 0) begin
                            state_q <= S_ACCUM;
                        end else begin
                            state_q  <= S_SETTLE;
                            settle_q <= SETTLE_LOAD;
                        end
                    end
                    S_SETTLE: begin
                        if (sample_pt) begin
                            settle_q <= settle_q - 14'd1;
                            if (settle_q == 14'd1) begin
                                state_q <= S_ACCUM;
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (window_close) begin
                            ones_q <= '0;
                            bits_q <= '0;
                        end else if (sample_pt) begin
                            ones_q <= ones_d;
                            bits_q <= bits_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mic_clk_o    = mic_clk_q;
    assign mic_lr_o     = 1'b0;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;

endmodule

// File: tb/tb_mic_pdm_capture.sv
// Bench for mic_pdm_capture with a cycle-level behavioural model of the
// capture: sample points every 2*DIV enabled cycles, settle windows discarded,
// saturated ones count per window, and a valid/rd handshake with overrun.
module tb_mic_pdm_capture;

    localparam int DIV    = 2;
    localparam int DECIM  = 8;
    localparam int SETTLE = 1;
    localparam int LOG2   = 3;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        mic_data_i;
    logic        rd_i;
    logic        mic_clk_o;
    logic        mic_lr_o;
    logic [15:0] dout_o;
    logic        dout_valid_o;
`ifdef MIC_OVERRUN_EN
    logic        overrun_o;
`endif

    int tests = 0;
    int fails = 0;

    int          ecount;
    int          settle_left;
    int          mode;
    int          win[$];
    bit          h1, h2;
    logic [15:0] exp_dout;
    bit          exp_valid;
    bit          exp_ovr;
    int          c;

    always #5 clk_i = ~clk_i;

    mic_pdm_capture #(
        .DIV   (DIV),
        .DECIM (DECIM),
        .SETTLE(SETTLE)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .mic_data_i  (mic_data_i),
        .rd_i        (rd_i),
        .mic_clk_o   (mic_clk_o),
        .mic_lr_o    (mic_lr_o),
        .dout_o      (dout_o),
        .dout_valid_o(dout_valid_o)
`ifdef MIC_OVERRUN_EN
        ,
        .overrun_o   (overrun_o)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ecount      = 0;
        settle_left = SETTLE * DECIM;
        win.delete();
        h1        = 1'b0;
        h2        = 1'b0;
        exp_dout  = 16'h0000;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_dout"}, dout_o, exp_dout);
        chk({pfx, "_dout_valid"}, {15'd0, dout_valid_o}, {15'd0, exp_valid});
        chk({pfx, "_mic_clk"}, {15'd0, mic_clk_o}, 16'((ecount / DIV) % 2));
`ifdef MIC_OVERRUN_EN
        chk({pfx, "_overrun"}, {15'd0, overrun_o}, {15'd0, exp_ovr});
`endif
    endtask

    // One clock: drive rd, advance the model for this edge, compare outputs.
    task automatic step(input bit rd_v);
        bit          b;
        bit          close;
        bit          sp;
        int          s;
        logic [15:0] newd;
        rd_i = rd_v;
        @(posedge clk_i);
        b     = h2;
        h2    = h1;
        h1    = mic_data_i;
        close = 1'b0;
        sp    = 1'b0;
        newd  = 16'h0000;
        if (en_i) begin
            ecount++;
            if (ecount % (2 * DIV) == 0) begin
                sp = 1'b1;
                if (settle_left > 0) begin
                    settle_left--;
                end else begin
                    win.push_back(int'(b));
                    if (win.size() == DECIM) begin
                        s = 0;
                        foreach (win[k]) s += win[k];
                        if (s > DECIM - 1) s = DECIM - 1;
                        newd  = 16'(s << (16 - LOG2));
                        close = 1'b1;
                        win.delete();
                    end
                end
            end
        end else begin
            ecount      = 0;
            settle_left = SETTLE * DECIM;
            win.delete();
        end
        if (close) begin
            if (exp_valid && !rd_v) exp_ovr = 1'b1;
            exp_dout  = newd;
            exp_valid = 1'b1;
        end else if (rd_v && exp_valid) begin
            exp_valid = 1'b0;
        end
        #1;
        check_outputs("cyc");
        case (mode)
            0:       mic_data_i = 1'b0;
            1:       mic_data_i = 1'b1;
            2:       if (sp) mic_data_i = ~mic_data_i;
            default: mic_data_i = 1'($urandom_range(0, 1));
        endcase
        rd_i = 1'b0;
    endtask

    // Step until the model's next window close (inclusive); cyc = cycles used.
    task automatic run_until_close(input bit rd_at, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (en_i && ((ecount + 1) % (2 * DIV) == 0) && settle_left == 0 &&
                win.size() == DECIM - 1) begin
                step(rd_at);
                done = 1'b1;
            end else begin
                step(1'b0);
            end
            cyc++;
        end
        tests++;
        assert (done) else begin
            fails++;
            $error("FAIL close_timeout: observed no window close, expected one within 1000 cycles");
        end
    endtask

    task automatic reset_now();
        reset_i = 1'b1;
        #1;
        model_reset();
        chk("rst_dout", dout_o, 16'h0000);
        chk("rst_valid", {15'd0, dout_valid_o}, 16'd0);
        chk("rst_mic_clk", {15'd0, mic_clk_o}, 16'd0);
`ifdef MIC_OVERRUN_EN
        chk("rst_overrun", {15'd0, overrun_o}, 16'd0);
`endif
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b0;
        en_i       = 1'b0;
        mic_data_i = 1'b0;
        rd_i       = 1'b0;
        mode       = 0;
        model_reset();
        #1;
        reset_now();
        chk("rst_mic_lr", {15'd0, mic_lr_o}, 16'd0);

        // Startup with constant ones: first sample after 8 settle + 8 window points.
        mode       = 1;
        mic_data_i = 1'b1;
        en_i       = 1'b1;
        for (int i = 0; i < 63; i++) step(1'b0);
        chk("startup_not_yet", {15'd0, dout_valid_o}, 16'd0);
        step(1'b0);
        chk("startup_valid", {15'd0, dout_valid_o}, 16'd1);
        chk("startup_dout", dout_o, 16'hE000);
        chk("mic_lr", {15'd0, mic_lr_o}, 16'd0);

        // Handshake: consume 3 cycles after valid, then rd while invalid.
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("hs_cleared", {15'd0, dout_valid_o}, 16'd0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk("hs_invalid_rd", {15'd0, dout_valid_o}, 16'd0);
        chk("hs_dout_stable", dout_o, 16'hE000);

        // Constant zeros, with rd coincident with the second close.
        mode = 0;
        run_until_close(1'b0, c);
        run_until_close(1'b1, c);
        chk("zeros_dout", dout_o, 16'h0000);
        chk("coincident_valid", {15'd0, dout_valid_o}, 16'd1);
`ifdef MIC_OVERRUN_EN
        chk("coincident_no_ovr", {15'd0, overrun_o}, 16'd0);
`endif

        // Alternating bits, never consumed: overwrite and overrun.
        mode = 2;
        run_until_close(1'b0, c);
        chk("alt_dout_1", dout_o, 16'h8000);
        run_until_close(1'b0, c);
        chk("alt_dout_2", dout_o, 16'h8000);
        chk("alt_valid", {15'd0, dout_valid_o}, 16'd1);
`ifdef MIC_OVERRUN_EN
        chk("ovr_set", {15'd0, overrun_o}, 16'd1);
`endif

        // Random data with random consumes, checked against the model.
        mode = 3;
        for (int i = 0; i < 400; i++) step($urandom_range(0, 7) == 0);

        // Drop enable 3 bits into a window, then re-enable.
        mode = 1;
        run_until_close(1'b1, c);
        for (int i = 0; i < 3 * 2 * DIV; i++) step(1'b0);
        en_i = 1'b0;
        step(1'b0);
        chk("endrop_mic_clk", {15'd0, mic_clk_o}, 16'd0);
        chk("endrop_valid", {15'd0, dout_valid_o}, 16'd1);
        step(1'b0);
        step(1'b1);
        en_i = 1'b1;
        run_until_close(1'b0, c);
        chk("reen_latency", 16'(c), 16'd64);
        chk("reen_dout", dout_o, 16'hE000);

        // Reset after 5 bits of a window; restart honours settle again.
        for (int i = 0; i < 5 * 2 * DIV; i++) step(1'b0);
        reset_now();
        run_until_close(1'b0, c);
        chk("postrst_latency", 16'(c), 16'd64);
        chk("postrst_dout", dout_o, 16'hE000);
        step(1'b1);
        chk("postrst_consume", {15'd0, dout_valid_o}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mic_pdm_capture.md
MIC_PDM_CAPTURE -- requirements
Module: mic_pdm_capture

Interface
REQ-001 Parameter DIV, default 25: clk cycles per mic_clk half-period; legal range 2..255.
REQ-002 Parameter DECIM, default 128: PDM bits per PCM sample; a power of two, legal range 8..1024.
REQ-003 Parameter SETTLE, default 4: number of whole windows discarded after en rises; legal range 0..15.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  asynchronous reset, active-high.
REQ-006 en  in  1  capture enable.
REQ-007 mic_data  in  1  PDM bit from the microphone; asynchronous to clk.
REQ-008 rd  in  1  one-cycle consume strobe from the downstream PWM stage (its done pulse).
REQ-009 mic_clk  out  1  registered microphone bit clock.
REQ-010 mic_lr  out  1  channel select; tied to 0.
REQ-011 dout  out  16  PCM sample feeding the PWM stage.
REQ-012 dout_valid  out  1  dout holds an unconsumed sample.
REQ-013 overrun  out  1  sticky lost-sample flag; present only with MIC_OVERRUN_EN.

Function
REQ-014 Clock divider: an 8-bit counter counts 0..DIV-1; at DIV-1 it wraps to 0 and mic_clk toggles.
REQ-015 While en=0, the divider holds at 0 and mic_clk holds at 0.
REQ-016 Input sync: mic_data passes through a 2-flop synchronizer, always clocked.
REQ-017 Bit sample point: the clk edge where the counter equals DIV-1 and mic_clk=1, i.e. the edge that drives mic_clk low.
REQ-018 State machine has three states: IDLE, SETTLE, ACCUM.
REQ-019 IDLE -> SETTLE when en=1; if SETTLE=0, IDLE -> ACCUM directly.
REQ-020 SETTLE: count sample points; after SETTLE*DECIM sample points -> ACCUM; no output is produced in SETTLE.
REQ-021 ACCUM: on each sample point, ones_cnt increments by the synchronized bit and bit_cnt increments.
REQ-022 When bit_cnt reaches DECIM, the window closes: both counters clear on that edge.
REQ-023 On window close, dout is loaded with min(ones_cnt, DECIM-1) << (16 - log2(DECIM)), including the closing bit; lower bits are 0.
REQ-024 On window close, dout_valid is set to 1 on the same edge as the dout load.
REQ-025 Latency: dout_valid rises on the edge of the DECIM-th sample point of the window.
REQ-026 Handshake: rd=1 while dout_valid=1 clears dout_valid on the next edge; dout is unchanged by rd.
REQ-027 rd while dout_valid=0 is ignored.
REQ-028 Window close while dout_valid=1 and rd=0: dout is overwritten, dout_valid stays 1, and an overrun event occurs.
REQ-029 Window close in the same cycle as rd: the new sample is loaded, dout_valid stays 1, and there is no overrun.
REQ-030 en falls in any state: -> IDLE on the next edge and the partial window is discarded; dout and dout_valid are kept.
REQ-031 ones_cnt and bit_cnt are log2(DECIM)+1 bits wide and never wrap.

Reset
REQ-032 Asserting reset immediately forces: state=IDLE, all counters 0, mic_clk=0, dout=16'h0000, dout_valid=0, overrun=0, and synchronizer flops 0.
REQ-033 Reset asserted mid-window discards the partial window; after release, capture resumes via IDLE, SETTLE is honoured again, and no partial sample is emitted.

Configuration
REQ-034 With MIC_OVERRUN_EN defined: overrun is set by the REQ-028 event, stays set until reset, and does not change dout_valid behaviour.
REQ-035 Without MIC_OVERRUN_EN: the overrun port and its logic are absent; REQ-028 data behaviour is otherwise identical.

Verification
REQ-036 The bench shall use DIV=2, DECIM=8, SETTLE=1 unless stated otherwise.
REQ-037 Startup: en=1 with mic_data=1 constant -> mic_clk period 4 clk; first dout_valid after 16 sample points (8 settle + 8 window); dout=16'hE000 (count 8 saturated to 7).
REQ-038 Constant mic_data=0 -> dout=16'h0000; alternating 1/0 per sample point -> dout=16'h8000.
REQ-039 Handshake: pulse rd 3 cycles after dout_valid -> dout_valid low next edge; rd repeated while invalid -> no effect; dout stable throughout.
REQ-040 Overrun (MIC_OVERRUN_EN): never assert rd across two windows -> second sample overwrites dout, overrun=1 and stays 1; rd coincident with window close -> overrun stays 0.
REQ-041 Reset mid-ACCUM after 5 bits -> all outputs 0 immediately; after release and en=1, the first sample appears only after a full SETTLE plus a full window.
REQ-042 en dropped after 3 bits of a window -> mic_clk 0, state IDLE, dout_valid and dout unchanged; re-enable produces a clean full window.
